led_pattern_driver: RTL

Downstream stage of the game controller. Consumes `leds_on`, `leds_ctrl[1:0]` and `clr` and turns them into a time-varying pattern on a bank of discrete LEDs. Four display modes: solid, blink, chase and bounce. It is clocked from the same 512 Hz game clock as the controller. A prescaler sets the pattern step rate.

---
 rtl/led_pattern_driver.sv | 115 +++++++++++
 1 files changed

// File: rtl/led_pattern_driver.sv
// LED pattern driver: turns the controller's enable/mode/clear into a stepped
// solid, blink, chase or bounce pattern on a bank of discrete LEDs.
module led_pattern_driver #(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned STEP_DIV = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              leds_on,
  input  logic [1:0]        leds_ctrl,
  input  logic              clr,
  output logic [N_LEDS-1:0] leds,
  output logic              step_pulse
);

  localparam int unsigned DivW = $clog2(STEP_DIV);
  localparam int unsigned PosW = $clog2(N_LEDS);

  localparam logic [1:0] ModeSolid  = 2'b00;
  localparam logic [1:0] ModeBlink  = 2'b01;
  localparam logic [1:0] ModeChase  = 2'b10;
  localparam logic [1:0] ModeBounce = 2'b11;

  localparam logic [DivW-1:0] DivLast   = DivW'(STEP_DIV - 1);
  localparam logic [PosW-1:0] PosLast   = PosW'(N_LEDS - 1);
  localparam logic [PosW-1:0] PosPenult = PosW'(N_LEDS - 2);
  localparam logic [PosW-1:0] PosOne    = PosW'(1);

  logic            en_q;
  logic [1:0]      mode_q;
  logic [DivW-1:0] div_cnt;
  logic [PosW-1:0] pos;
  logic            dir;
  logic            phase;

  logic [PosW-1:0] pos_adv;
  logic            dir_adv;
  logic            phase_adv;

  // Next pattern state for one step in the current mode.
  always_comb begin
    pos_adv   = pos;
    dir_adv   = dir;
    phase_adv = phase;
    case (mode_q)
      ModeBlink: phase_adv = ~phase;
      ModeChase: pos_adv = (pos == PosLast) ? '0 : pos + PosOne;
      ModeBounce: begin
        if (!dir) begin
          pos_adv = pos + PosOne;
          // Turn around in the same update so the endpoint shows for one step only.
          if (pos == PosPenult) dir_adv = 1'b1;
        end else begin
          pos_adv = pos - PosOne;
          if (pos == PosOne) dir_adv = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Enable, mode tracking, step prescaler and pattern state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      mode_q     <= ModeSolid;
      div_cnt    <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      phase      <= 1'b0;
      step_pulse <= 1'b0;
    end else if (clr || !leds_on) begin
      en_q       <= 1'b0;
      mode_q     <= leds_ctrl;
      div_cnt    <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      phase      <= 1'b0;
      step_pulse <= 1'b0;
    end else if (!en_q || (leds_ctrl != mode_q)) begin
      // Fresh enable or mode change: restart at frame 0 with a full step period.
      en_q       <= 1'b1;
      mode_q     <= leds_ctrl;
      div_cnt    <= '0;
      pos        <= '0;
      dir        <= 1'b0;
      phase      <= 1'b0;
      step_pulse <= 1'b0;
    end else if (div_cnt != DivLast) begin
      en_q       <= 1'b1;
      div_cnt    <= div_cnt + DivW'(1);
      step_pulse <= 1'b0;
    end else begin
      en_q       <= 1'b1;
      div_cnt    <= '0;
      pos        <= pos_adv;
      dir        <= dir_adv;
      phase      <= phase_adv;
      step_pulse <= 1'b1;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    leds = '0;
    if (en_q) begin
      case (mode_q)
        ModeSolid: leds = '1;
        ModeBlink: leds = phase ? '0 : '1;
        default:   leds[pos] = 1'b1;
      endcase
    end
  end

endmodule
